// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and helpers for the AES-128 key scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Round constant for round 1..10, already placed in the top byte of the word
    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [31:0] r;
        case (idx)
            4'd1:    r = 32'h0100_0000;
            4'd2:    r = 32'h0200_0000;
            4'd3:    r = 32'h0400_0000;
            4'd4:    r = 32'h0800_0000;
            4'd5:    r = 32'h1000_0000;
            4'd6:    r = 32'h2000_0000;
            4'd7:    r = 32'h4000_0000;
            4'd8:    r = 32'h8000_0000;
            4'd9:    r = 32'h1b00_0000;
            4'd10:   r = 32'h3600_0000;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_sched_if.sv
// ============================================================================
// Module      : aes_key_sched_if
// Description : Request/round-key bundle between controller and key scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface aes_key_sched_if;
    logic         start;
    logic         dir;
    logic [127:0] key;
    logic [127:0] roundKey;
    logic         cipherReset;
    logic         done;
    logic         outValid;
    logic         busy;

    modport master (
        output start, dir, key,
        input  roundKey, cipherReset, done, outValid, busy
    );

    modport slave (
        input  start, dir, key,
        output roundKey, cipherReset, done, outValid, busy
    );
endinterface

`default_nettype wire

// File: rtl/aes_key_sched_subword.sv
// ============================================================================
// Module      : subword
// Description : Four forward AES S-boxes applied bytewise to a 32-bit word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module subword (
    input  wire logic [31:0] i_word,
    output logic      [31:0] o_word
);

    // Entry 0x00 sits in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    generate
        for (genvar i = 0; i < 4; i++) begin : g_sbox
            assign o_word[8*i +: 8] = c_SBOX[{~i_word[8*i +: 8], 3'b000} +: 8];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/aes_key_sched.sv
// ============================================================================
// Module      : aes_key_sched
// Description : Iterative AES-128 key scheduler, one round key per cycle,
//               regenerating keys backwards for decryption.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module aes_key_sched
    import aes_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset_n,
    aes_key_sched_if.slave bus
);

    localparam logic [3:0] c_LAST_RND = 4'(NR);

    state_t       r_state;
    logic [3:0]   r_rnd;
    logic         r_dir;
    logic [127:0] r_key;
    logic [127:0] r_rk;

    logic         w_inv;
    logic [3:0]   w_rcon_idx;
    logic [31:0]  w_rcon;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [31:0]  w_inv3;
    logic [31:0]  w_sub_in, w_sub_out;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [127:0] w_fwd, w_bwd, w_step;

    assign {w_k0, w_k1, w_k2, w_k3} = r_key;

    // Inverse stepping is used only once the forward pre-expansion is complete
    assign w_inv      = r_dir && (r_state != PREP);
    assign w_rcon_idx = w_inv ? (c_LAST_RND - r_rnd) : (r_rnd + 4'd1);
    assign w_rcon     = rcon(w_rcon_idx);

    assign w_inv3   = w_k3 ^ w_k2;
    assign w_sub_in = rot_word(w_inv ? w_inv3 : w_k3);

    subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    assign w_f0  = w_k0 ^ w_sub_out ^ w_rcon;
    assign w_f1  = w_k1 ^ w_f0;
    assign w_f2  = w_k2 ^ w_f1;
    assign w_f3  = w_k3 ^ w_f2;
    assign w_fwd = {w_f0, w_f1, w_f2, w_f3};

    assign w_bwd  = {w_k0 ^ w_sub_out ^ w_rcon, w_k1 ^ w_k0, w_k2 ^ w_k1, w_inv3};
    assign w_step = w_inv ? w_bwd : w_fwd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rnd   <= 4'd0;
            r_dir   <= 1'b0;
            r_key   <= 128'd0;
            r_rk    <= 128'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_key <= bus.key;
                        r_dir <= bus.dir;
                        r_rnd <= 4'd0;
                        if (bus.dir) begin
                            r_state <= PREP;
                        end else begin
                            r_state <= LOAD;
                            r_rk    <= bus.key;
                        end
                    end
                end
                PREP: begin
                    // Output key stays frozen here; counter restarts for the reverse walk
                    r_key <= w_step;
                    if (r_rnd == c_LAST_RND - 4'd1) begin
                        r_rnd   <= 4'd0;
                        r_rk    <= w_step;
                        r_state <= LOAD;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                LOAD: begin
                    r_key   <= w_step;
                    r_rk    <= w_step;
                    r_rnd   <= 4'd1;
                    r_state <= RUN;
                end
                RUN: begin
                    if (r_rnd == c_LAST_RND) begin
                        r_state <= FIN;
                    end else begin
                        r_key <= w_step;
                        r_rk  <= w_step;
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.roundKey    = r_rk;
    assign bus.cipherReset = (r_state == LOAD);
    assign bus.outValid    = (r_state == RUN) && (r_rnd == c_LAST_RND);
    assign bus.done        = !((r_state == LOAD) || ((r_state == RUN) && (r_rnd != c_LAST_RND)));
    assign bus.busy        = (r_state == PREP) || (r_state == LOAD) || (r_state == RUN);

endmodule

`default_nettype wire
